dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the datapath's 256 x 16 data memory. It shares the single memory port between the CPU load/store path (port 0) and a loader/debug requester (port 1), such as a bench-side program/data preloader. Each granted access runs a fixed four-state sequence so both requesters see uniform, deterministic latency.

---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports and the data-memory port
// around dmem_arbiter.
//   pN_req/we/addr/wdata : request fields from requester N (N = 0 CPU, 1 loader)
//   pN_ack/rdata         : one-cycle completion and sticky read data to requester N
//   mem_en/we/addr/wdata : single-port memory access, mem_rdata one cycle later
//   busy/gnt_id          : arbiter status
// modport slave is the arbiter's view; modport master is the surrounding system's.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic [DW-1:0] p1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          gnt_id;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, gnt_id
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, gnt_id
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer for a single-port data memory.
// Every granted access runs IDLE -> ISSUE -> READ -> ACK, giving a fixed 3-cycle
// request-to-ack latency and 4-cycle occupancy.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : dmem_arbiter_if.slave (requester ports, memory port, busy/gnt_id status)
// All outputs are registered.
module dmem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StRead, StAck} state_e;

  state_e        state_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          p0_ack_q;
  logic          p1_ack_q;
  logic [DW-1:0] p0_rdata_q;
  logic [DW-1:0] p1_rdata_q;
  logic          busy_q;
  logic          gnt_id_q;
  logic          last_gnt_q;

  logic any_req;
  logic win;

  // On a tie the port that did not win last time goes; last_gnt resets to 1 so
  // port 0 takes the first tie after reset.
  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
    if (bus.p0_req && bus.p1_req) begin
      win = ~last_gnt_q;
    end else begin
      win = bus.p1_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      busy_q      <= 1'b0;
      gnt_id_q    <= 1'b0;
      last_gnt_q  <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_id_q    <= win;
            last_gnt_q  <= win;
            mem_we_q    <= win ? bus.p1_we    : bus.p0_we;
            mem_addr_q  <= win ? bus.p1_addr  : bus.p0_addr;
            mem_wdata_q <= win ? bus.p1_wdata : bus.p0_wdata;
            mem_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          // mem_we stays latched; it is only meaningful while mem_en is high.
          mem_en_q <= 1'b0;
          state_q  <= StRead;
        end
        StRead: begin
          if (!mem_we_q) begin
            if (gnt_id_q) p1_rdata_q <= bus.mem_rdata;
            else          p0_rdata_q <= bus.mem_rdata;
          end
          if (gnt_id_q) p1_ack_q <= 1'b1;
          else          p0_ack_q <= 1'b1;
          state_q <= StAck;
        end
        StAck: begin
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p0_ack    = p0_ack_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a 256 x 16 memory model
// preloaded with mem[i] = i.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic preload;
  int   checks;
  int   failures;
  int   n;
  int   n0;
  int   n1;
  logic [15:0] mem [256];

  dmem_arbiter_if #(.AW(8), .DW(16)) bus ();

  dmem_arbiter #(.AW(8), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write at the mem_en edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until an ack is visible or lim ticks elapse; returns ticks taken.
  task automatic wait_ack(input int lim, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(bus.p0_ack || bus.p1_ack) && cnt < lim);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    preload = 1'b1;
    rst = 1'b1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd5; bus.p0_wdata = 16'h0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'd9; bus.p1_wdata = 16'h0;

    // Reset held 4 cycles with both requests high: everything stays at 0.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_outputs",
            {2'b0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.p0_ack,
             bus.p1_ack, bus.p0_rdata, bus.p1_rdata, bus.busy, bus.gnt_id}, 64'h0);
    end
    preload = 1'b0;
    rst = 1'b0;

    // Tie after reset: p0 reads 5 first, p1 reads 9 four cycles later.
    tick();
    check("tie_first_gnt", bus.gnt_id, 0);
    check("tie_issue", {bus.busy, bus.mem_en, bus.mem_addr}, {2'b11, 8'd5});
    tick();
    check("issue_one_cycle", {bus.busy, bus.mem_en}, 2'b10);
    tick();
    check("tie_p0_ack", {bus.p0_ack, bus.p1_ack, bus.p0_rdata}, {2'b10, 16'h0005});
    bus.p0_req = 1'b0;
    wait_ack(8, n);
    check("tie_p1_gap", n, 4);
    check("tie_p1_ack", {bus.p0_ack, bus.p1_ack, bus.p1_rdata, bus.gnt_id},
          {2'b01, 16'h0009, 1'b1});
    check("tie_p0_rdata_kept", bus.p0_rdata, 16'h0005);
    bus.p1_req = 1'b0;
    tick();
    check("idle_after_ack", {bus.busy, bus.p1_ack}, 2'b00);

    // Sustained contention: 4 reads each, grants alternate starting at port 0.
    bus.p0_req = 1'b1; bus.p0_addr = 8'd100;
    bus.p1_req = 1'b1; bus.p1_addr = 8'd200;
    n0 = 0;
    n1 = 0;
    for (int t = 0; t < 8; t++) begin
      wait_ack(8, n);
      check("cont_gap", n, (t == 0) ? 3 : 4);
      if (t % 2 == 0) begin
        check("cont_p0", {bus.p0_ack, bus.p1_ack, bus.gnt_id, bus.p0_rdata},
              {3'b100, 16'(100 + n0)});
        n0++;
        if (n0 == 4) bus.p0_req = 1'b0;
        else         bus.p0_addr = 8'(100 + n0);
      end else begin
        check("cont_p1", {bus.p0_ack, bus.p1_ack, bus.gnt_id, bus.p1_rdata},
              {3'b011, 16'(200 + n1)});
        n1++;
        if (n1 == 4) bus.p1_req = 1'b0;
        else         bus.p1_addr = 8'(200 + n1);
      end
    end
    tick();

    // Port 0 write mem[22]=0x0042, then read it back.
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'd22; bus.p0_wdata = 16'h0042;
    tick();
    check("wr_issue", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.gnt_id},
          {2'b11, 8'd22, 16'h0042, 1'b0});
    wait_ack(8, n);
    check("wr_latency", n, 2);
    check("wr_ack_rdata_kept", {bus.p0_ack, bus.p0_rdata}, {1'b1, 16'd103});
    bus.p0_we = 1'b0;
    wait_ack(8, n);
    check("rd_gap", n, 4);
    check("rd_back", {bus.p0_ack, bus.p0_rdata}, {1'b1, 16'h0042});
    check("rd_p1_untouched", bus.p1_rdata, 16'd203);
    bus.p0_req = 1'b0;
    tick();

    // p1 writes mem[40]=0xBEEF, p0 requests a read of 40 during p1's ack cycle.
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'd40; bus.p1_wdata = 16'hBEEF;
    wait_ack(8, n);
    check("p1_wr_ack", {bus.p1_ack, bus.gnt_id, bus.p1_rdata}, {2'b11, 16'd203});
    bus.p1_req = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 8'd40;
    wait_ack(8, n);
    check("order_gap", n, 4);
    check("order_rdata", {bus.p0_ack, bus.gnt_id, bus.p0_rdata}, {2'b10, 16'hBEEF});
    bus.p0_req = 1'b0;
    tick();

    // Reset during READ of a p0 read, then the re-issued request completes.
    bus.p0_req = 1'b1; bus.p0_addr = 8'd7;
    tick();
    check("pre_abort_busy", bus.busy, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("abort_state", {bus.p0_ack, bus.p0_rdata, bus.busy, bus.mem_en, bus.gnt_id},
          {1'b0, 16'h0, 3'b000});
    rst = 1'b0;
    wait_ack(8, n);
    check("reissue_latency", n, 3);
    check("reissue_rdata", {bus.p0_ack, bus.p0_rdata}, {1'b1, 16'h0007});
    bus.p0_req = 1'b0;
    tick();
    check("final_idle", {bus.busy, bus.p0_ack}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
